mem_addr_sequencer: RTL and testbench

- Parametrised, registered successor of the memory-address source selector in the multicycle datapath.
- Selects among N_SRC external address sources (PC, ALUOut, A, B, ...) and N_EXC constant exception-vector addresses (EXC_BASE+k).
- Holds the selected address in a register and can run a byte-burst: consecutive addresses stepped on memory handshake, e.g. fetching handler bytes or unaligned words.
- Sits between the control unit and the Memory address port.

---
 rtl/mem_addr_pkg.sv | 6 +
 rtl/mem_addr_sequencer_if.sv | 25 ++
 rtl/addr_src_mux.sv | 30 +++
 rtl/mem_addr_sequencer.sv | 92 +++++++++
 tb/tb_mem_addr_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_addr_pkg.sv
// mem_addr_pkg: shared FSM state type and default constants for the address sequencer.
package mem_addr_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  localparam int EXC_BASE_DEFAULT = 253;
  localparam int N_EXC_DEFAULT = 3;
endpackage

// File: rtl/mem_addr_sequencer_if.sv
// mem_addr_sequencer_if: control-side inputs and memory-side outputs of the address sequencer.
interface mem_addr_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4,
  parameter int N_EXC = mem_addr_pkg::N_EXC_DEFAULT,
  parameter int MAX_BURST = 4
);
  localparam int SEL_W = $clog2(N_SRC + N_EXC);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  logic [N_SRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0] sel;
  logic load;
  logic burst_start;
  logic [LEN_W-1:0] burst_len;
  logic mem_ready;
  logic [WIDTH-1:0] addr;
  logic addr_valid;
  logic busy;
  logic done;
  logic err;
  modport master(output src_bus, sel, load, burst_start, burst_len, mem_ready,
                 input addr, addr_valid, busy, done, err);
  modport slave(input src_bus, sel, load, burst_start, burst_len, mem_ready,
                output addr, addr_valid, busy, done, err);
endinterface

// File: rtl/addr_src_mux.sv
// addr_src_mux: picks an external source or a constant exception vector, flagging out-of-range selects.
module addr_src_mux #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4,
  parameter int N_EXC = 3,
  parameter int EXC_BASE = 253,
  parameter int SEL_W = 3
) (
  input  logic [N_SRC*WIDTH-1:0] src_bus_i,
  input  logic [SEL_W-1:0]       sel_i,
  output logic [WIDTH-1:0]       addr_o,
  output logic                   valid_o
);
  always_comb begin
    addr_o = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_i == SEL_W'(i)) begin
        addr_o = src_bus_i[i*WIDTH +: WIDTH];
        valid_o = 1'b1;
      end
    end
    for (int k = 0; k < N_EXC; k++) begin
      if (sel_i == SEL_W'(N_SRC + k)) begin
        addr_o = WIDTH'(EXC_BASE + k);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_addr_sequencer.sv
// mem_addr_sequencer: registered memory-address selector with handshake-stepped byte bursts.
module mem_addr_sequencer
  import mem_addr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4,
  parameter int N_EXC = N_EXC_DEFAULT,
  parameter int EXC_BASE = EXC_BASE_DEFAULT,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic reset,
  mem_addr_sequencer_if.slave bus
);
  localparam int SEL_W = $clog2(N_SRC + N_EXC);
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  state_e state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, sel_addr;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic valid_q, valid_d, done_q, done_d, err_q, err_d, sel_ok, len_ok;

  addr_src_mux #(.WIDTH(WIDTH), .N_SRC(N_SRC), .N_EXC(N_EXC), .EXC_BASE(EXC_BASE), .SEL_W(SEL_W)) u_mux (
    .src_bus_i(bus.src_bus),
    .sel_i(bus.sel),
    .addr_o(sel_addr),
    .valid_o(sel_ok)
  );

  assign len_ok = bus.burst_len != '0 && bus.burst_len <= LEN_W'(MAX_BURST);

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    valid_d = valid_q;
    len_d = len_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.burst_start) begin
        err_d = !(sel_ok && len_ok);
        if (sel_ok && len_ok) begin
          addr_d = sel_addr;
          valid_d = 1'b1;
          len_d = bus.burst_len;
          cnt_d = '0;
          state_d = BURST;
        end
      end else if (bus.load) begin
        err_d = !sel_ok;
        addr_d = sel_ok ? sel_addr : addr_q;
        valid_d = sel_ok ? 1'b1 : valid_q;
      end
    end else if (bus.mem_ready) begin
      // last beat keeps its address; only the handshake flags drop
      if (cnt_q < len_q - LEN_W'(1)) begin
        addr_d = addr_q + WIDTH'(1);
        cnt_d = cnt_q + LEN_W'(1);
      end else begin
        done_d = 1'b1;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      valid_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      valid_q <= valid_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign bus.addr = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.busy = state_q == BURST;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_mem_addr_sequencer.sv
// tb_mem_addr_sequencer: directed vector table, a long stall, then random traffic against a reference model.
module tb_mem_addr_sequencer;
  logic clk = 1'b0;
  logic reset;
  int n_cmp = 0;
  int n_bad = 0;

  mem_addr_sequencer_if bus();

  mem_addr_sequencer dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [2:0] sel;
    logic ld;
    logic bs;
    logic [2:0] len;
    logic rdy;
    logic [31:0] a;
    logic v;
    logic b;
    logic d;
    logic e;
  } vec_t;

  vec_t tv[$];

  logic [31:0] src[4];
  logic [31:0] m_addr;
  logic m_valid, e_done, e_err;
  int m_left;

  task automatic add(input int rst, input int sel, input int ld, input int bs, input int len,
                     input int rdy, input logic [31:0] a, input int v, input int b, input int d, input int e);
    vec_t t;
    t.rst = rst[0];
    t.sel = 3'(sel);
    t.ld = ld[0];
    t.bs = bs[0];
    t.len = 3'(len);
    t.rdy = rdy[0];
    t.a = a;
    t.v = v[0];
    t.b = b[0];
    t.d = d[0];
    t.e = e[0];
    tv.push_back(t);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input logic [31:0] a, input logic v, input logic b,
                         input logic d, input logic e);
    cmp({tag, " addr"}, bus.addr, a);
    cmp({tag, " addr_valid"}, 32'(bus.addr_valid), 32'(v));
    cmp({tag, " busy"}, 32'(bus.busy), 32'(b));
    cmp({tag, " done"}, 32'(bus.done), 32'(d));
    cmp({tag, " err"}, 32'(bus.err), 32'(e));
  endtask

  task automatic drive_src();
    bus.src_bus = {src[3], src[2], src[1], src[0]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // spec rule: 0..3 external, 4..6 are 253..255, anything else invalid
  function automatic bit ref_sel(input int s, output logic [31:0] a);
    a = 32'h0;
    if (s < 4) a = src[s];
    else if (s < 7) a = 32'(253 + s - 4);
    return s < 7;
  endfunction

  task automatic mdl_step();
    logic [31:0] a;
    bit ok;
    e_done = 1'b0;
    e_err = 1'b0;
    ok = ref_sel(int'(bus.sel), a);
    if (reset) begin
      m_addr = 32'h0;
      m_valid = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      if (bus.mem_ready) begin
        if (m_left > 1) m_addr = m_addr + 32'h1;
        else begin
          e_done = 1'b1;
          m_valid = 1'b0;
        end
        m_left--;
      end
    end else if (bus.burst_start) begin
      if (ok && bus.burst_len >= 1 && bus.burst_len <= 4) begin
        m_addr = a;
        m_valid = 1'b1;
        m_left = int'(bus.burst_len);
      end else e_err = 1'b1;
    end else if (bus.load) begin
      if (ok) begin
        m_addr = a;
        m_valid = 1'b1;
      end else e_err = 1'b1;
    end
  endtask

  initial begin
    src[0] = 32'hFFFF_FFFE;
    src[1] = 32'h0000_1000;
    src[2] = 32'hDEAD_BEEF;
    src[3] = 32'h1234_5678;
    drive_src();
    reset = 1'b0;
    bus.sel = '0;
    bus.load = 1'b0;
    bus.burst_start = 1'b0;
    bus.burst_len = '0;
    bus.mem_ready = 1'b0;

    //  rst sel ld bs len rdy addr            v  b  d  e
    add(1, 0, 0, 0, 0, 0, 32'h0,           0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 32'h1000,        1, 0, 0, 0);
    add(0, 5, 1, 0, 0, 0, 32'd254,         1, 0, 0, 0);
    add(0, 7, 1, 0, 0, 0, 32'd254,         1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 32'd254,         1, 0, 0, 0);
    add(0, 4, 0, 1, 3, 1, 32'd253,         1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'd254,         1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'd255,         1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'd255,         0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 32'd255,         0, 0, 0, 0);
    add(0, 0, 0, 1, 4, 1, 32'hFFFF_FFFE,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0,           1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1,           1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1,           0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 32'h1,           0, 0, 0, 1);
    add(0, 2, 0, 1, 5, 1, 32'h1,           0, 0, 0, 1);
    add(0, 1, 1, 1, 2, 0, 32'h1000,        1, 1, 0, 0);
    add(0, 6, 1, 0, 0, 0, 32'h1000,        1, 1, 0, 0);
    add(0, 7, 0, 1, 0, 1, 32'h1001,        1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h1001,        0, 0, 1, 0);
    add(0, 4, 0, 1, 1, 0, 32'd253,         1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'd253,         0, 0, 1, 0);
    add(0, 0, 0, 1, 4, 1, 32'hFFFF_FFFE,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 1, 32'h0,           0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 32'h0,           0, 0, 0, 0);

    @(negedge clk);
    foreach (tv[i]) begin
      reset = tv[i].rst;
      bus.sel = tv[i].sel;
      bus.load = tv[i].ld;
      bus.burst_start = tv[i].bs;
      bus.burst_len = tv[i].len;
      bus.mem_ready = tv[i].rdy;
      step();
      cmp_all($sformatf("vec%0d", i), tv[i].a, tv[i].v, tv[i].b, tv[i].d, tv[i].e);
    end

    // a long memory stall must hold the beat with no timeout
    reset = 1'b0;
    bus.sel = 3'd3;
    bus.burst_start = 1'b1;
    bus.burst_len = 3'd2;
    bus.mem_ready = 1'b0;
    step();
    bus.burst_start = 1'b0;
    for (int c = 0; c < 30; c++) step();
    cmp_all("stall", 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    step();
    cmp_all("stall beat2", 32'h1234_5679, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    cmp_all("stall end", 32'h1234_5679, 1'b0, 1'b0, 1'b1, 1'b0);

    reset = 1'b1;
    mdl_step();
    step();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        src[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
        drive_src();
      end
      reset = ($urandom_range(0, 199) == 0);
      bus.sel = 3'($urandom_range(0, 7));
      bus.load = ($urandom_range(0, 3) == 0);
      bus.burst_start = ($urandom_range(0, 4) == 0);
      bus.burst_len = 3'($urandom_range(0, 7));
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      mdl_step();
      step();
      cmp_all($sformatf("rnd%0d", c), m_addr, m_valid, m_left > 0, e_done, e_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
